ram_bist_ctrl: RTL and testbench

//   Synthesizable initiator for the single-port RAM (clk/addr/data_in/data_out/wea).
//   On start: writes a seed-derived pattern to every word, reads back and compares,

---
 rtl/ram_bist_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// March-style write/read-back BIST initiator for a single-port RAM.
// Two passes: seed-derived pattern, then its full-width inverse.
module ram_bist_ctrl #(
    parameter int unsigned        ADDR_W = 8,
    parameter int unsigned        DATA_W = 16,
    parameter logic [DATA_W-1:0]  SEED   = 16'hA5A5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W+1:0] err_cnt,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {StIdle, StWr0, StRd0, StWr1, StRd1, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return SEED ^ DATA_W'(a);
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                drain_q, drain_d;
    logic                wea_q, wea_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [ADDR_W+1:0]   err_cnt_q, err_cnt_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        err_cnt_d   = err_cnt_q;

        // Expected data travels one cycle behind the issued read address.
        cmp_valid_d = ((state_q == StRd0) || (state_q == StRd1)) && !drain_q;
        exp_d       = (state_q == StRd1) ? ~pattern(addr_q) : pattern(addr_q);
        cmp_addr_d  = addr_q;

        if (cmp_valid_q && (ram_rdata != exp_q)) begin
            if (err_cnt_q == '0) begin
                fail_addr_d = cmp_addr_q;
            end
            err_cnt_d = err_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StWr0;
                    addr_d      = '0;
                    drain_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    err_cnt_d   = '0;
                end
            end
            StWr0, StWr1: begin
                if (addr_q == LastAddr) begin
                    state_d = (state_q == StWr0) ? StRd0 : StRd1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StRd0, StRd1: begin
                if (drain_q) begin
                    state_d = (state_q == StRd0) ? StWr1 : StDone;
                    addr_d  = '0;
                    drain_d = 1'b0;
                end else if (addr_q == LastAddr) begin
                    drain_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
                drain_d = 1'b0;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        wea_d   = (state_d == StWr0) || (state_d == StWr1);
        wdata_d = '0;
        if (state_d == StWr0) begin
            wdata_d = pattern(addr_d);
        end else if (state_d == StWr1) begin
            wdata_d = ~pattern(addr_d);
        end
        busy_d = (state_d == StWr0) || (state_d == StRd0) ||
                 (state_d == StWr1) || (state_d == StRd1);
        done_d = (state_d == StDone);
        if (state_d == StDone) begin
            pass_d = (err_cnt_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            drain_q     <= 1'b0;
            wea_q       <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            wea_q       <= wea_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            err_cnt_q   <= err_cnt_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign err_cnt   = err_cnt_q;
    assign ram_wea   = wea_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: faulty-RAM model, reference error model and run-timing checks.
module tb_ram_bist_ctrl;

    localparam int          AW   = 8;
    localparam int          DW   = 16;
    localparam int          N    = 256;
    localparam logic [15:0] SEED = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, ram_wea;
    logic [AW-1:0] fail_addr, ram_addr;
    logic [AW+1:0] err_cnt;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_cnt   (err_cnt),
        .ram_wea   (ram_wea),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM with per-address read fault: rdata = (stored & and_m) | or_m
    logic [DW-1:0] mem   [N];
    logic [DW-1:0] and_m [N];
    logic [DW-1:0] or_m  [N];
    logic [DW-1:0] rd_raw = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW+DW-1:0] wlog[$];

    always @(posedge clk) begin
        if (ram_wea === 1'b1) begin
            mem[ram_addr] <= ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
        end
        rd_raw  <= mem[ram_addr];
        rd_addr <= ram_addr;
    end

    assign ram_rdata = (rd_raw & and_m[rd_addr]) | or_m[rd_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            and_m[a] = 16'hFFFF;
            or_m[a]  = 16'h0000;
        end
    endtask

    function automatic logic [15:0] pat(input int a, input int ph);
        logic [15:0] p;
        p = SEED ^ 16'(a);
        return (ph != 0) ? ~p : p;
    endfunction

    // Whole-test expectation from the fault map: each address written then read, two passes.
    task automatic ref_model(output int errs, output int faddr);
        logic [15:0] w, r;
        errs  = 0;
        faddr = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < N; a++) begin
                w = pat(a, ph);
                r = (w & and_m[a]) | or_m[a];
                if (r != w) begin
                    if (errs == 0) faddr = a;
                    errs++;
                end
            end
        end
    endtask

    function automatic int exp_addr(input int n);
        if (n >= 1 && n <= 256)    return n - 1;
        if (n >= 257 && n <= 512)  return n - 257;
        if (n == 513)              return 255;
        if (n >= 514 && n <= 769)  return n - 514;
        if (n >= 770 && n <= 1025) return n - 770;
        if (n == 1026)             return 255;
        return 0;
    endfunction

    task automatic run_and_check(input string tag, input bit repulse);
        int errs, faddr;
        int busy_bad, wea_bad, addr_bad, done_cnt, done_at, log_bad;
        logic [AW+DW-1:0] e;
        ref_model(errs, faddr);
        busy_bad = 0; wea_bad = 0; addr_bad = 0; done_cnt = 0; done_at = 0; log_bad = 0;
        wlog.delete();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 1040; n++) begin
            @(negedge clk);
            start = repulse && (n == 10 || n == 1027);
            if (busy !== (n >= 1 && n <= 1026)) busy_bad++;
            if (ram_wea !== ((n >= 1 && n <= 256) || (n >= 514 && n <= 769))) wea_bad++;
            if (int'(ram_addr) != exp_addr(n)) addr_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
        end
        start = 1'b0;
        for (int i = 0; i < wlog.size() && i < 2 * N; i++) begin
            e = {8'(i % N), pat(i % N, i / N)};
            if (wlog[i] !== e) log_bad++;
        end
        check_eq({tag, "_busy_window"}, busy_bad, 0);
        check_eq({tag, "_wea_window"}, wea_bad, 0);
        check_eq({tag, "_addr_seq"}, addr_bad, 0);
        check_eq({tag, "_done_count"}, done_cnt, 1);
        check_eq({tag, "_done_at"}, done_at, 1027);
        check_eq({tag, "_pass"}, pass, (errs == 0));
        check_eq({tag, "_err_cnt"}, err_cnt, errs);
        check_eq({tag, "_fail_addr"}, fail_addr, faddr);
        check_eq({tag, "_wlog_size"}, wlog.size(), 2 * N);
        check_eq({tag, "_wlog_data"}, log_bad, 0);
    endtask

    task automatic reset_mid(input int n_rst);
        int dn;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= n_rst; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        check_eq("rst_mid_wea", ram_wea, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_results", {pass, fail_addr, err_cnt}, 0);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        check_eq("rst_mid_no_done", dn, 0);
        rst = 1'b1;
    endtask

    initial begin
        int dn, first, second;
        for (int a = 0; a < N; a++) mem[a] = '0;
        clear_faults();
        repeat (2) @(negedge clk);
        check_eq("reset_ctrl", {busy, done, pass, ram_wea, ram_addr}, 0);
        check_eq("reset_data", {fail_addr, err_cnt, ram_wdata}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_and_check("ideal", 1'b0);

        clear_faults();
        or_m[8'h10] = 16'h0008;
        run_and_check("stuck_bit3", 1'b0);

        clear_faults();
        and_m[8'h20] = 16'h0000;
        and_m[8'h80] = 16'h0000;
        run_and_check("zero_words", 1'b0);

        clear_faults();
        reset_mid(300);
        reset_mid($urandom_range(2, 1020));
        run_and_check("after_reset", 1'b0);

        run_and_check("repulse", 1'b1);

        // start held high: back-to-back runs separated by one IDLE cycle
        dn = 0; first = 0; second = 0;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn++;
                if (dn == 1) first = n;
                else if (dn == 2) second = n;
            end
        end
        start = 1'b0;
        check_eq("held_done_count", dn, 2);
        check_eq("held_done_gap", second - first, 1028);
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        for (int it = 0; it < 4; it++) begin
            int nf, a;
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int j = 0; j < nf; j++) begin
                a = $urandom_range(0, N - 1);
                and_m[a] = 16'($urandom);
                or_m[a]  = 16'($urandom) & 16'h00FF;
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_and_check($sformatf("rand%0d", it), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
